// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch queue.
package fetch_pkg;
  localparam int WORD_W = 30;
  localparam logic [WORD_W-1:0] PC_STEP = 30'h4;
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch entries with flush and a registered head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  fetch_entry_t head_q, head_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, rem;
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    rem = cnt_q - CW'(pop);
    // a word pushed into an (effectively) empty queue becomes the head directly
    head_d = (flush || cnt_d == '0) ? head_q : (push && rem == '0) ? din : mem[rd_d];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= din;
  end
  assign head = head_q;
  assign count = cnt_q;
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetch with redirect flush.
// Optional PREFETCH_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module instr_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, count;
  fetch_entry_t head, din;
  logic fire, fresh, byp, push, pop, fifo_valid;
  always_comb begin
    fifo_valid = count != '0;
    imem_req = ~reset & ~redirect & (count + outst_q < CW'(DEPTH));
    imem_addr = fetch_pc_q;
    fire = imem_req & imem_ready;
    fresh = imem_rvalid & (discard_q == '0) & ~redirect;
`ifdef PREFETCH_BYPASS_EN
    byp = fresh & ~fifo_valid;
`else
    byp = 1'b0;
`endif
    push = fresh & ~(byp & ~stall);
    pop = fifo_valid & ~stall & ~redirect;
    instr_valid = fifo_valid | byp;
    instr = byp ? imem_rdata : WIDTH'(head.instr);
    instr_pc = byp ? resp_pc_q : WIDTH'(head.pc);
    din = '{instr: WORD_W'(imem_rdata), pc: WORD_W'(resp_pc_q)};
    outst_d = outst_q + CW'(fire) - CW'(imem_rvalid);
    // every request still in flight at a redirect returns stale data
    discard_d = redirect ? outst_d : discard_q - CW'(imem_rvalid & (discard_q != '0));
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + (fire ? WIDTH'(PC_STEP) : '0);
    resp_pc_d = redirect ? redirect_pc
              : resp_pc_q + ((imem_rvalid && discard_q == '0) ? WIDTH'(PC_STEP) : '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q <= '0;
      discard_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q <= outst_d;
      discard_q <= discard_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .din(din),
    .head(head),
    .count(count)
  );
  a_no_resp_when_full: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && count == CW'(DEPTH)));
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: random and directed checks against a stream-level fetch model.
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, redirect = 1'b0, stall = 1'b0;
  logic imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [29:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, instr_valid;
  logic [29:0] imem_addr, instr, instr_pc;
  instr_prefetch_queue #(.DEPTH(DEPTH), .WIDTH(30), .RESET_PC(30'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [29:0] a;
    int ep;
    int due;
  } req_t;
  req_t memq[$];
  int vecs = 0, errs = 0, cyc_n = 0, last_due = 0, epoch = 0, occ = 0;
  logic [29:0] exp_pc, exp_issue;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    imem_ready = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", {2'b0, instr}, 32'd0);
    chk("rst_pc", {2'b0, instr_pc}, 32'd0);
    chk("rst_addr", {2'b0, imem_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    memq.delete();
    occ = 0;
    exp_pc = '0;
    exp_issue = '0;
    epoch++;
    cyc_n = 0;
    last_due = 0;
  endtask
  task automatic cyc(input bit st, input bit rd, input logic [29:0] rpc, input bit rdy, input int lat);
    bit rv, fresh, byp_e, ev, er, consume, popq;
    req_t r;
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    imem_ready = rdy;
    rv = memq.size() > 0 && memq[0].due <= cyc_n;
    imem_rvalid = rv;
    imem_rdata = rv ? memq[0].a + 30'h100 : 30'h2aaaaaaa;
    #1;
    fresh = rv && memq[0].ep == epoch && !rd;
    byp_e = BYP && occ == 0 && fresh;
    ev = occ != 0 || byp_e;
    er = !rd && (occ + memq.size() < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, er});
    chk("imem_addr", {2'b0, imem_addr}, {2'b0, exp_issue});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
    if (ev) begin
      chk("instr_pc", {2'b0, instr_pc}, {2'b0, exp_pc});
      chk("instr", {2'b0, instr}, {2'b0, exp_pc + 30'h100});
    end
    consume = byp_e && !st;
    popq = occ != 0 && !st && !rd;
    if (ev && !st && !rd) exp_pc += 30'd4;
    occ = rd ? 0 : occ + int'(fresh && !consume) - int'(popq);
    if (rv) void'(memq.pop_front());
    if (er && rdy) begin
      r.a = exp_issue;
      r.ep = epoch;
      r.due = (cyc_n + lat > last_due + 1) ? cyc_n + lat : last_due + 1;
      last_due = r.due;
      memq.push_back(r);
      exp_issue += 30'd4;
    end
    if (rd) begin
      exp_pc = rpc;
      exp_issue = rpc;
      epoch++;
    end
    cyc_n++;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 3);
    cyc(0, 1, 30'h200, 1, 3);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 30'h300, 1, 1);
    cyc(0, 1, 30'h400, 1, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 30'h3FFFFFF8, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
          ($urandom_range(0, 3) == 0) ? 30'h3FFFFFF0 : ($urandom() & 30'h3FFFFFFC),
          $urandom_range(0, 3) != 0, $urandom_range(1, 4));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
